// File: rtl/vga_plot_sink.sv
// Pixel-plot sink: queues plot/clear requests in order, clips and linearises
// coordinates, and drains them into a single-port framebuffer write port.
module vga_plot_sink #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    x,
  input  logic [7:0]                    y,
  input  logic [2:0]                    color,
  input  logic                          plot,
  input  logic                          clear_req,
  input  logic [2:0]                    clear_color,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [2:0]                    mem_data,
  output logic                          mem_we,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    overflow_cnt,
  output logic [7:0]                    clip_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] W_L = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] H_L = ADDR_W'(HEIGHT);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t state, state_nxt;

  // Entry layout: {type (1 = clear), addr, color}
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic              in_range, push_req, push_ok, full, pop, accept, clipped;
  logic              next_valid, load;
  logic [ADDR_W-1:0] plot_addr;
  logic [ENT_W-1:0]  push_entry, head, next_head, load_ent;
  logic [1:0]        ov_inc;
  logic [8:0]        ov_sum;

  assign in_range   = (ADDR_W'(x) < W_L) && (ADDR_W'(y) < H_L);
  assign plot_addr  = ADDR_W'(y) * W_L + ADDR_W'(x);
  assign push_req   = clear_req | (plot & in_range);
  assign push_entry = clear_req ? {1'b1, {ADDR_W{1'b0}}, clear_color}
                                : {1'b0, plot_addr, color};
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_req & ~full;
  assign clipped    = plot & ~clear_req & ~in_range;
  assign head       = fifo_mem[rd_ptr];
  assign accept     = mem_we & mem_ready;
  assign pop        = accept & ((state == WRITE) |
                                ((state == CLEAR) & (mem_addr == LAST_ADDR)));
  assign ov_inc     = {1'b0, clear_req & plot} + {1'b0, push_req & full};
  assign ov_sum     = {1'b0, overflow_cnt} + {7'b0, ov_inc};
  assign fifo_count = count;

  // Head after a pop: the second entry, or the entry being pushed this cycle
  // when only one was queued, so back-to-back traffic never bubbles.
  always_comb begin
    next_valid = 1'b0;
    next_head  = push_entry;
    if (count > CNT_W'(1)) begin
      next_valid = 1'b1;
      next_head  = fifo_mem[rd_ptr + PTR_W'(1)];
    end else if (push_ok) begin
      next_valid = 1'b1;
    end
  end

  assign load     = ((state == IDLE) & (count != '0)) | (pop & next_valid);
  assign load_ent = (state == IDLE) ? head : next_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = head[ENT_W-1] ? CLEAR : WRITE;
      end
      default: begin
        if (pop) begin
          if (next_valid) state_nxt = next_head[ENT_W-1] ? CLEAR : WRITE;
          else            state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mem_we = (state != IDLE);
    busy   = (state != IDLE) | (count != '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // mem_addr doubles as the clear counter while a clear token is draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (load) begin
      mem_addr <= load_ent[ENT_W-1] ? '0 : load_ent[ENT_W-2:3];
      mem_data <= load_ent[2:0];
    end else if (accept && state == CLEAR) begin
      mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= '0;
      clip_cnt     <= '0;
    end else begin
      overflow_cnt <= ov_sum[8] ? 8'hFF : ov_sum[7:0];
      if (clipped && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
    end
  end

endmodule
